// File: rtl/badapple_pkg.sv
// Shared types and helpers for the frame bank sequencer and its pointer counters.
package badapple_pkg;

   localparam int unsigned MAX_BANKS = 8;
   localparam int unsigned PTR_W     = $clog2(MAX_BANKS);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPrime = 2'd1,
      StRun   = 2'd2
   } seq_state_t;

   function automatic logic [MAX_BANKS-1:0] onehot_bank(input logic [PTR_W-1:0] ptr);
      logic [MAX_BANKS-1:0] oh;
      oh      = '0;
      oh[ptr] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N bank pointer with increment and synchronous clear.
module wrap_counter
   import badapple_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_cnt
);

   logic [PTR_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= (32'(r_cnt) == N - 1) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/frame_bank_sequencer.sv
// Circular-queue frame bank sequencer: fills banks ahead of display, repeats on underrun.
// Optional UNDERRUN_CNT_EN adds a 16-bit saturating underrun counter port.
module frame_bank_sequencer
   import badapple_pkg::*;
#(
   parameter int unsigned NUM_BANKS   = 2,
   parameter int unsigned PRIME_DEPTH = 1
) (
   input  logic                           CLK_40,
   input  logic                           reset,
   input  logic                           init,
   input  logic                           frame_start,
   input  logic                           write_done,
   output logic                           start_req,
   output logic                           write_active,
   output logic [NUM_BANKS-1:0]           write_sel,
   output logic                           read_valid,
   output logic [NUM_BANKS-1:0]           read_sel,
   output logic [$clog2(NUM_BANKS+1)-1:0] queued,
   output logic                           underrun,
`ifdef UNDERRUN_CNT_EN
   output logic                           protocol_err,
   output logic [15:0]                    underrun_cnt
`else
   output logic                           protocol_err
`endif
);

   localparam int unsigned CW = $clog2(NUM_BANKS + 1);

   seq_state_t       r_state;
   logic [CW-1:0]    r_count;
   logic             r_disp;
   logic             r_write_active;
   logic             r_start_req;
   logic             r_underrun;
   logic             r_protocol_err;
   logic [PTR_W-1:0] w_wp;
   logic [PTR_W-1:0] w_rp;

   logic w_active;
   logic w_launch;
   logic w_wr_done;
   logic w_fs;
   logic w_first;
   logic w_adv;
   logic w_urun;
   logic w_pop;

   // init overrides every other event in the cycle it arrives.
   assign w_active  = (r_state != StIdle) && !init;
   assign w_launch  = w_active && !r_write_active &&
                      ((32'(r_count) + 32'(r_disp)) < NUM_BANKS);
   assign w_wr_done = w_active && write_done && r_write_active;
   assign w_fs      = w_active && frame_start;
   assign w_first   = w_fs && (r_state == StPrime) && (32'(r_count) >= PRIME_DEPTH);
   assign w_adv     = w_fs && (r_state == StRun) && (r_count != '0);
   assign w_urun    = w_fs && (r_state == StRun) && (r_count == '0);
   assign w_pop     = w_first || w_adv;

   wrap_counter #(
      .N (NUM_BANKS)
   ) u_wp (
      .i_clk (CLK_40),
      .i_rst (reset),
      .i_clr (init),
      .i_inc (w_wr_done),
      .o_cnt (w_wp)
   );

   wrap_counter #(
      .N (NUM_BANKS)
   ) u_rp (
      .i_clk (CLK_40),
      .i_rst (reset),
      .i_clr (init),
      .i_inc (w_adv),
      .o_cnt (w_rp)
   );

   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) begin
         r_state        <= StIdle;
         r_count        <= '0;
         r_disp         <= 1'b0;
         r_write_active <= 1'b0;
         r_start_req    <= 1'b0;
         r_underrun     <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_start_req    <= w_launch;
         r_underrun     <= w_urun;
         r_protocol_err <= write_done && !r_write_active;
         if (init) begin
            r_state        <= StPrime;
            r_count        <= '0;
            r_disp         <= 1'b0;
            r_write_active <= 1'b0;
         end else if (w_active) begin
            if (w_launch) begin
               r_write_active <= 1'b1;
            end else if (w_wr_done) begin
               r_write_active <= 1'b0;
            end
            // Pop decision used the pre-increment count; both edits land together.
            r_count <= r_count + CW'(w_wr_done) - CW'(w_pop);
            if (w_first) begin
               r_state <= StRun;
               r_disp  <= 1'b1;
            end
         end
      end
   end

`ifdef UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge CLK_40 or posedge reset) begin
      if (reset) begin
         r_underrun_cnt <= '0;
      end else if (init) begin
         r_underrun_cnt <= '0;
      end else if (w_urun && (r_underrun_cnt != 16'hFFFF)) begin
         r_underrun_cnt <= r_underrun_cnt + 16'd1;
      end
   end

   assign underrun_cnt = r_underrun_cnt;
`endif

   assign start_req    = r_start_req;
   assign write_active = r_write_active;
   assign write_sel    = r_write_active ? NUM_BANKS'(onehot_bank(w_wp)) : '0;
   assign read_valid   = r_disp;
   assign read_sel     = r_disp ? NUM_BANKS'(onehot_bank(w_rp)) : '0;
   assign queued       = r_count;
   assign underrun     = r_underrun;
   assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_frame_bank_sequencer.sv
// Bench for frame_bank_sequencer: a 2-bank and a 4-bank instance against a bank-list model.
module tb_frame_bank_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // index 0 drives the 2-bank instance, index 1 the 4-bank instance
   logic [1:0] i_init, i_fs, i_wd;

   logic       s2_sr, s2_wa, s2_rv, s2_ur, s2_pe;
   logic [1:0] s2_ws, s2_rs, s2_q;
   logic       s4_sr, s4_wa, s4_rv, s4_ur, s4_pe;
   logic [3:0] s4_ws, s4_rs;
   logic [2:0] s4_q;
`ifdef UNDERRUN_CNT_EN
   logic [15:0] s2_uc, s4_uc;
`endif

   frame_bank_sequencer #(.NUM_BANKS(2), .PRIME_DEPTH(1)) dut2 (
      .CLK_40(clk), .reset(rst), .init(i_init[0]), .frame_start(i_fs[0]),
      .write_done(i_wd[0]), .start_req(s2_sr), .write_active(s2_wa), .write_sel(s2_ws),
      .read_valid(s2_rv), .read_sel(s2_rs), .queued(s2_q), .underrun(s2_ur),
`ifdef UNDERRUN_CNT_EN
      .underrun_cnt(s2_uc),
`endif
      .protocol_err(s2_pe)
   );

   frame_bank_sequencer #(.NUM_BANKS(4), .PRIME_DEPTH(3)) dut4 (
      .CLK_40(clk), .reset(rst), .init(i_init[1]), .frame_start(i_fs[1]),
      .write_done(i_wd[1]), .start_req(s4_sr), .write_active(s4_wa), .write_sel(s4_ws),
      .read_valid(s4_rv), .read_sel(s4_rs), .queued(s4_q), .underrun(s4_ur),
`ifdef UNDERRUN_CNT_EN
      .underrun_cnt(s4_uc),
`endif
      .protocol_err(s4_pe)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc_no = 0;

   // Reference model: mode 0 idle, 1 priming, 2 running; full banks kept as an ordered list.
   int m_mode[2], m_wp[2], m_shown[2], m_fill[2], m_len[2], m_uc[2];
   int m_list[2][8];
   bit m_st[2], m_ur[2], m_pe[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_wp[k] = 0; m_shown[k] = -1; m_fill[k] = -1;
         m_len[k] = 0; m_uc[k] = 0; m_st[k] = 0; m_ur[k] = 0; m_pe[k] = 0;
      end
   endtask

   task automatic model_step(input int k, input int nb, input int pd,
                             input bit ini, input bit fs, input bit wd);
      bit launch;
      m_pe[k] = wd && (m_fill[k] < 0);
      m_st[k] = 0;
      m_ur[k] = 0;
      if (ini) begin
         m_mode[k] = 1; m_wp[k] = 0; m_len[k] = 0; m_shown[k] = -1; m_fill[k] = -1;
         m_uc[k] = 0;
      end else if (m_mode[k] != 0) begin
         launch = (m_fill[k] < 0) && (m_len[k] + ((m_shown[k] >= 0) ? 1 : 0) < nb);
         if (fs) begin
            if ((m_mode[k] == 1 && m_len[k] >= pd) || (m_mode[k] == 2 && m_len[k] > 0)) begin
               m_shown[k] = m_list[k][0];
               for (int i = 1; i < m_len[k]; i++) m_list[k][i-1] = m_list[k][i];
               m_len[k]--;
               m_mode[k] = 2;
            end else if (m_mode[k] == 2) begin
               m_ur[k] = 1;
               if (m_uc[k] < 65535) m_uc[k]++;
            end
         end
         if (wd && m_fill[k] >= 0) begin
            m_list[k][m_len[k]] = m_fill[k];
            m_len[k]++;
            m_wp[k] = (m_wp[k] + 1) % nb;
            m_fill[k] = -1;
         end
         if (launch) begin
            m_fill[k] = m_wp[k];
            m_st[k] = 1;
         end
      end
   endtask

   function automatic logic [24:0] dut_vec(input int k);
      if (k == 0) return {s2_sr, s2_wa, 8'(s2_ws), s2_rv, 8'(s2_rs), 4'(s2_q), s2_ur, s2_pe};
      return {s4_sr, s4_wa, 8'(s4_ws), s4_rv, 8'(s4_rs), 4'(s4_q), s4_ur, s4_pe};
   endfunction

   function automatic logic [24:0] exp_vec(input int k);
      logic [7:0] ws, rs;
      ws = (m_fill[k] >= 0) ? 8'(1 << m_fill[k]) : 8'h00;
      rs = (m_shown[k] >= 0) ? 8'(1 << m_shown[k]) : 8'h00;
      return {m_st[k], m_fill[k] >= 0, ws, m_shown[k] >= 0, rs, 4'(m_len[k]), m_ur[k], m_pe[k]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, got, exp);
      end
   endtask

   task automatic compare(input int k);
      chk(k == 0 ? "model dut2" : "model dut4", 32'(dut_vec(k)), 32'(exp_vec(k)));
`ifdef UNDERRUN_CNT_EN
      chk(k == 0 ? "ucnt dut2" : "ucnt dut4", 32'(k == 0 ? s2_uc : s4_uc), 32'(m_uc[k]));
`endif
   endtask

   task automatic cyc(input bit in2, input bit f2, input bit w2,
                      input bit in4, input bit f4, input bit w4);
      i_init = {in4, in2};
      i_fs   = {f4, f2};
      i_wd   = {w4, w2};
      @(posedge clk);
      #1;
      cyc_no++;
      model_step(0, 2, 1, in2, f2, w2);
      model_step(1, 4, 3, in4, f4, w4);
      compare(0);
      compare(1);
   endtask

   typedef struct {
      bit ini, fs, wd;
      bit sr, wa; bit [1:0] ws; bit rv; bit [1:0] rs; bit [1:0] q; bit ur, pe;
      int uc;
   } vec_t;

   function automatic vec_t mk(bit ini, bit fs, bit wd, bit sr, bit wa, bit [1:0] ws, bit rv,
                               bit [1:0] rs, bit [1:0] q, bit ur, bit pe, int uc);
      vec_t v;
      v.ini = ini; v.fs = fs; v.wd = wd; v.sr = sr; v.wa = wa; v.ws = ws; v.rv = rv;
      v.rs = rs; v.q = q; v.ur = ur; v.pe = pe; v.uc = uc;
      return v;
   endfunction

   vec_t tbl[18];

   initial begin
      //          ini fs wd  sr wa ws     rv rs     q  ur pe uc
      tbl[0]  = mk(1, 0, 0,  0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0,  1, 1, 2'b01, 0, 2'b00, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0,  0, 1, 2'b01, 0, 2'b00, 0, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1,  0, 0, 2'b00, 0, 2'b00, 1, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0,  1, 1, 2'b10, 0, 2'b00, 1, 0, 0, 0);
      tbl[5]  = mk(0, 1, 0,  0, 1, 2'b10, 1, 2'b01, 0, 0, 0, 0);
      tbl[6]  = mk(0, 1, 0,  0, 1, 2'b10, 1, 2'b01, 0, 1, 0, 1);
      tbl[7]  = mk(0, 1, 1,  0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 2);
      tbl[8]  = mk(0, 0, 0,  0, 0, 2'b00, 1, 2'b01, 1, 0, 0, 2);
      tbl[9]  = mk(0, 1, 0,  0, 0, 2'b00, 1, 2'b10, 0, 0, 0, 2);
      tbl[10] = mk(0, 0, 0,  1, 1, 2'b01, 1, 2'b10, 0, 0, 0, 2);
      tbl[11] = mk(0, 0, 1,  0, 0, 2'b00, 1, 2'b10, 1, 0, 0, 2);
      tbl[12] = mk(0, 0, 1,  0, 0, 2'b00, 1, 2'b10, 1, 0, 1, 2);
      tbl[13] = mk(1, 0, 0,  0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      tbl[14] = mk(0, 0, 0,  1, 1, 2'b01, 0, 2'b00, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 0,  0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 1,  1, 1, 2'b01, 0, 2'b00, 0, 0, 1, 0);
      tbl[17] = mk(0, 0, 0,  0, 1, 2'b01, 0, 2'b00, 0, 0, 0, 0);

      model_reset();
      i_init = '0; i_fs = '0; i_wd = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compare(0);
      compare(1);
      chk("reset dut2 outputs", 32'(dut_vec(0)), 32'd0);
      rst = 1'b0;

      // Directed ping-pong, underrun, simultaneous pop+fill, stray done, restart.
      for (int i = 0; i < 18; i++) begin
         cyc(tbl[i].ini, tbl[i].fs, tbl[i].wd, 0, 0, 0);
         chk($sformatf("table row %0d", i),
             32'({s2_sr, s2_wa, s2_ws, s2_rv, s2_rs, s2_q, s2_ur, s2_pe}),
             32'({tbl[i].sr, tbl[i].wa, tbl[i].ws, tbl[i].rv, tbl[i].rs, tbl[i].q,
                  tbl[i].ur, tbl[i].pe}));
`ifdef UNDERRUN_CNT_EN
         chk($sformatf("table ucnt %0d", i), 32'(s2_uc), 32'(tbl[i].uc));
`endif
      end

      // Four banks, prime depth three, then display with no further frames.
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("p4 first start", 32'({s4_sr, s4_ws}), 32'(5'b10001));
      cyc(0, 0, 0, 0, 1, 0);
      chk("p4 early frame", 32'(s4_rv), 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p4 queued 1", 32'(s4_q), 32'd1);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0);
      chk("p4 frame at 2", 32'(s4_rv), 32'd0);
      cyc(0, 0, 0, 0, 0, 1);
      chk("p4 third done", 32'({s4_rv, s4_q}), 32'(4'b0011));
      cyc(0, 0, 0, 0, 0, 0);
      chk("p4 fourth start", 32'({s4_sr, s4_ws}), 32'(5'b11000));
      cyc(0, 0, 0, 0, 1, 0);
      chk("p4 display", 32'({s4_rv, s4_rs, s4_q}), 32'(8'b1_0001_010));
      cyc(0, 0, 0, 0, 0, 1);
      chk("p4 queued 3", 32'(s4_q), 32'd3);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         chk($sformatf("p4 full hold %0d", i), 32'({s4_sr, s4_wa, s4_q}), 32'(5'b00011));
      end

      // Random traffic on both instances.
      for (int n = 0; n < 800; n++) begin
         bit ini[2], fs[2], wd[2];
         for (int k = 0; k < 2; k++) begin
            ini[k] = ($urandom_range(63) == 0);
            fs[k]  = ($urandom_range(3) == 0);
            wd[k]  = (m_fill[k] >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(39) == 0);
         end
         cyc(ini[0], fs[0], wd[0], ini[1], fs[1], wd[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
